// File: rtl/tlul_host_arb_pkg.sv
// Types shared by the TL-UL host arbiter and its tracking FIFO.
package tlul_host_arb_pkg;

    localparam int MaxHosts = 8;

    typedef logic [$clog2(MaxHosts)-1:0] host_idx_t;

    typedef enum logic {
        Idle,
        Locked
    } arb_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by hosts, devices and interconnect blocks.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_fifo.sv
// In-order FIFO of winning host indices; the head names the owner of the next response.
module tlul_host_arb_fifo
    import tlul_host_arb_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  host_idx_t                wdata,
    input  logic                     pop,
    output host_idx_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   depth
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = Depth[CntW-1:0];

    host_idx_t       mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: storage is deliberately not reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PtrW'(1);
            if (do_pop)  rptr <= rptr + PtrW'(1);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == FullCount);
    assign empty = (count == '0);
    assign depth = count;

endmodule

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one TL-UL device among several hosts; responses are
// steered back through an in-order FIFO of winner indices.
module tlul_host_arb
    import tlul_pkg::*;
    import tlul_host_arb_pkg::*;
#(
    parameter int NumHosts       = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  tl_h2d_t                           tl_h_i [NumHosts],
    output tl_d2h_t                           tl_h_o [NumHosts],
    output tl_h2d_t                           tl_d_o,
    input  tl_d2h_t                           tl_d_i,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic                              err_o
);

    localparam int HostIdxW = $clog2(NumHosts);

    arb_state_e          state;
    logic [HostIdxW-1:0] rr_ptr;
    logic [HostIdxW-1:0] rr_next;
    host_idx_t           locked_idx;
    host_idx_t           grant_idx;
    host_idx_t           head_idx;
    logic                grant_vld;
    logic                head_d_ready;
    logic                fifo_full;
    logic                fifo_empty;
    logic                a_hs;
    logic                d_hs;
    logic [NumHosts-1:0] a_req;

    always_comb begin
        a_req = '0;
        for (int h = 0; h < NumHosts; h++) a_req[h] = tl_h_i[h].a_valid;
    end

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin : rr_search
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == Locked) begin
            grant_vld = 1'b1;
            grant_idx = locked_idx;
        end else if (!fifo_full) begin
            // Scan from farthest to nearest so the host closest after rr_ptr is assigned last and wins.
            for (int i = NumHosts - 1; i >= 0; i--) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NumHosts) cand = cand - NumHosts;
                if (a_req[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = host_idx_t'(cand);
                end
            end
        end
    end

    // NOTE: handshake outputs are forced low straight from rst_i so they never depend on inputs during reset.
    always_comb begin
        tl_d_o       = '0;
        head_d_ready = 1'b0;
        for (int h = 0; h < NumHosts; h++) begin
            tl_h_o[h] = '0;
            if (grant_vld && grant_idx == host_idx_t'(h)) tl_d_o = tl_h_i[h];
            if (!fifo_empty && head_idx == host_idx_t'(h)) begin
                tl_h_o[h]    = tl_d_i;
                head_d_ready = tl_h_i[h].d_ready;
            end
            tl_h_o[h].a_ready = grant_vld && (grant_idx == host_idx_t'(h)) && tl_d_i.a_ready && !rst_i;
            if (rst_i) tl_h_o[h].d_valid = 1'b0;
        end
        tl_d_o.d_ready = fifo_empty ? 1'b1 : head_d_ready;
        if (rst_i) begin
            tl_d_o.a_valid = 1'b0;
            tl_d_o.d_ready = 1'b0;
        end
    end

    assign a_hs    = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs    = tl_d_i.d_valid & tl_d_o.d_ready & ~fifo_empty;
    assign rr_next = (grant_idx == host_idx_t'(NumHosts - 1)) ? '0
                   : HostIdxW'(grant_idx + host_idx_t'(1));

    tlul_host_arb_fifo #(
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (a_hs),
        .wdata (grant_idx),
        .pop   (d_hs),
        .rdata (head_idx),
        .full  (fifo_full),
        .empty (fifo_empty),
        .depth (outstanding_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= Idle;
            rr_ptr     <= '0;
            locked_idx <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= tl_d_i.d_valid & fifo_empty;
            case (state)
                Idle: begin
                    if (a_hs) begin
                        rr_ptr <= rr_next;
                    end else if (grant_vld) begin
                        locked_idx <= grant_idx;
                        state      <= Locked;
                    end
                end
                Locked: begin
                    if (a_hs) begin
                        rr_ptr <= rr_next;
                        state  <= Idle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Randomized bench for tlul_host_arb: hosts and device are modelled here, and every
// cycle the DUT is compared against a queue-based model of the arbitration rules.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int NH = 4;
    localparam int MO = 4;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t tl_h_i [NH];
    tl_d2h_t tl_h_o [NH];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;
    logic [2:0] outstanding_o;
    logic    err_o;

    tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tl_h_i        (tl_h_i),
        .tl_h_o        (tl_h_o),
        .tl_d_o        (tl_d_o),
        .tl_d_i        (tl_d_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int          rr;
    int          sticky;
    int          q_host[$];
    logic [31:0] q_addr[$];
    bit          pend [NH];
    logic [31:0] paddr [NH];
    int          seq;
    bit          dv;
    bit          dv_orphan;
    logic [31:0] dv_data;
    bit          exp_err;

    // Stimulus knobs
    logic [NH-1:0] host_en;
    int req_pct, ready_pct, resp_pct, orphan_pct;
    int dready_pct [NH];

    // Observations of DUT behaviour for scenario checks
    int obs_acc [NH];
    int obs_resp [NH];
    int resp_order[$];
    int peak;
    int obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pend_any();
        bit r = 1'b0;
        for (int h = 0; h < NH; h++) r |= pend[h];
        return r;
    endfunction

    task automatic model_reset();
        rr = 0;
        sticky = -1;
        q_host.delete();
        q_addr.delete();
        dv = 1'b0;
        dv_orphan = 1'b0;
        dv_data = '0;
        exp_err = 1'b0;
        for (int h = 0; h < NH; h++) pend[h] = 1'b0;
    endtask

    task automatic quiet_knobs();
        host_en = '0;
        req_pct = 100;
        ready_pct = 100;
        resp_pct = 100;
        orphan_pct = 0;
        for (int h = 0; h < NH; h++) dready_pct[h] = 100;
    endtask

    task automatic clear_obs();
        for (int h = 0; h < NH; h++) begin
            obs_acc[h] = 0;
            obs_resp[h] = 0;
        end
        resp_order.delete();
        peak = 0;
        obs_err = 0;
    endtask

    task automatic drive();
        for (int h = 0; h < NH; h++) begin
            if (!pend[h] && host_en[h] && $urandom_range(99) < req_pct) begin
                pend[h] = 1'b1;
                paddr[h] = {8'(h), 24'(seq)};
                seq++;
            end
            tl_h_i[h] = '0;
            tl_h_i[h].a_valid   = pend[h];
            tl_h_i[h].a_opcode  = 3'd4;
            tl_h_i[h].a_size    = 2'd2;
            tl_h_i[h].a_mask    = 4'hf;
            tl_h_i[h].a_source  = 8'(h);
            tl_h_i[h].a_address = paddr[h];
            tl_h_i[h].d_ready   = ($urandom_range(99) < dready_pct[h]);
        end
        if (!dv) begin
            if (q_host.size() > 0 && $urandom_range(99) < resp_pct) begin
                dv = 1'b1;
                dv_orphan = 1'b0;
                dv_data = q_addr[0];
            end else if (q_host.size() == 0 && $urandom_range(99) < orphan_pct) begin
                dv = 1'b1;
                dv_orphan = 1'b1;
                dv_data = 32'hdead_0000 | 32'(seq);
            end
        end
        tl_d_i = '0;
        tl_d_i.a_ready  = ($urandom_range(99) < ready_pct);
        tl_d_i.d_valid  = dv;
        tl_d_i.d_opcode = 3'd1;
        tl_d_i.d_size   = 2'd2;
        tl_d_i.d_data   = dv_data;
    endtask

    task automatic drive_noise();
        for (int h = 0; h < NH; h++) begin
            tl_h_i[h] = '0;
            tl_h_i[h].a_valid   = 1'($urandom_range(1));
            tl_h_i[h].d_ready   = 1'($urandom_range(1));
            tl_h_i[h].a_address = $urandom;
        end
        tl_d_i = '0;
        tl_d_i.a_ready = 1'b1;
        tl_d_i.d_valid = 1'b1;
        tl_d_i.d_data  = $urandom;
    endtask

    task automatic check_reset();
        logic [NH-1:0] ar;
        logic [NH-1:0] dvv;
        for (int h = 0; h < NH; h++) begin
            ar[h]  = tl_h_o[h].a_ready;
            dvv[h] = tl_h_o[h].d_valid;
        end
        check("rst_a_valid", 64'(tl_d_o.a_valid), 64'(0));
        check("rst_d_ready", 64'(tl_d_o.d_ready), 64'(0));
        check("rst_host_a_ready", 64'(ar), 64'(0));
        check("rst_host_d_valid", 64'(dvv), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
    endtask

    task automatic sample();
        int g;
        bit found;
        bit acc;
        bit pop;
        logic [NH-1:0] exp_ar, got_ar, exp_dv, got_dv;
        g = -1;
        found = 1'b0;
        if (q_host.size() < MO) begin
            if (sticky >= 0) g = sticky;
            else begin
                for (int k = 0; k < NH; k++) begin
                    if (!found && pend[(rr + k) % NH]) begin
                        g = (rr + k) % NH;
                        found = 1'b1;
                    end
                end
            end
        end
        acc = (g >= 0) && tl_d_i.a_ready;
        exp_ar = '0;
        if (acc) exp_ar[g] = 1'b1;
        exp_dv = '0;
        if (dv && !dv_orphan) exp_dv[q_host[0]] = 1'b1;
        for (int h = 0; h < NH; h++) begin
            got_ar[h] = tl_h_o[h].a_ready;
            got_dv[h] = tl_h_o[h].d_valid;
        end

        check("a_valid", 64'(tl_d_o.a_valid), 64'(g >= 0));
        if (g >= 0) check("a_address", 64'(tl_d_o.a_address), 64'(paddr[g]));
        check("a_ready", 64'(got_ar), 64'(exp_ar));
        check("d_valid", 64'(got_dv), 64'(exp_dv));
        if (dv && !dv_orphan) check("d_data", 64'(tl_h_o[q_host[0]].d_data), 64'(dv_data));
        if (q_host.size() > 0) check("d_ready", 64'(tl_d_o.d_ready), 64'(tl_h_i[q_host[0]].d_ready));
        else if (dv) check("d_ready_orphan", 64'(tl_d_o.d_ready), 64'(1));
        check("outstanding", 64'(outstanding_o), 64'(q_host.size()));
        check("err", 64'(err_o), 64'(exp_err));

        for (int h = 0; h < NH; h++) begin
            if (tl_h_o[h].a_ready && tl_h_i[h].a_valid) obs_acc[h]++;
            if (tl_h_o[h].d_valid && tl_h_i[h].d_ready) begin
                obs_resp[h]++;
                resp_order.push_back(h);
            end
        end
        if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
        if (err_o) obs_err++;

        pop = dv && (dv_orphan || tl_h_i[q_host[0]].d_ready);
        exp_err = dv && dv_orphan;
        if (pop) begin
            if (!dv_orphan) begin
                void'(q_host.pop_front());
                void'(q_addr.pop_front());
            end
            dv = 1'b0;
        end
        if (acc) begin
            q_host.push_back(g);
            q_addr.push_back(paddr[g]);
            pend[g] = 1'b0;
            rr = (g + 1) % NH;
            sticky = -1;
        end else if (g >= 0) begin
            sticky = g;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        quiet_knobs();
        while ((q_host.size() > 0 || pend_any() || dv) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_done", 64'(n < 200), 64'(1));
    endtask

    task automatic issue_one(input int h);
        int start = obs_acc[h];
        int n = 0;
        host_en = NH'(1 << h);
        while (obs_acc[h] == start && n < 20) begin
            cycle();
            n++;
        end
        host_en = '0;
        check("issue_one", 64'(obs_acc[h] - start), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ord;
        seq = 0;
        rst = 1'b1;
        quiet_knobs();
        model_reset();
        clear_obs();
        drive_noise();
        repeat (3) begin
            @(negedge clk);
            check_reset();
            @(posedge clk);
            #1 drive_noise();
        end
        rst = 1'b0;
        model_reset();
        drive();

        // Grant lock: hosts 0 and 1 wait while the device stalls
        host_en = 4'b0011;
        ready_pct = 0;
        resp_pct = 0;
        repeat (5) cycle();
        check("lock_no_accept", 64'(obs_acc[0] + obs_acc[1]), 64'(0));
        ready_pct = 100;
        host_en = '0;
        cycle();
        check("lock_host0_first", 64'(obs_acc[0] * 16 + obs_acc[1]), 64'(16));
        cycle();
        check("lock_host1_next", 64'(obs_acc[1]), 64'(1));
        drain();

        // Single host, back-to-back Gets with 1-cycle responses
        clear_obs();
        host_en = 4'b0100;
        n = 0;
        while (obs_acc[2] < 3 && n < 30) begin
            cycle();
            n++;
            if (obs_acc[2] >= 3) host_en = '0;
        end
        drain();
        check("single_acc", 64'(obs_acc[2]), 64'(3));
        check("single_resp", 64'(obs_resp[2]), 64'(3));
        check("single_other_resp", 64'(obs_resp[0] + obs_resp[1] + obs_resp[3]), 64'(0));
        check("single_peak", 64'(peak), 64'(1));

        // Fairness: all hosts request continuously
        clear_obs();
        host_en = '1;
        repeat (64) cycle();
        host_en = '0;
        for (int h = 0; h < NH; h++) check("fair_share", 64'(obs_acc[h]), 64'(16));
        drain();

        // Full FIFO: device never responds
        clear_obs();
        host_en = 4'b1000;
        resp_pct = 0;
        repeat (8) cycle();
        host_en = '0;
        check("full_outstanding", 64'(outstanding_o), 64'(MO));
        check("full_stall_ready", 64'(tl_h_o[3].a_ready), 64'(0));
        check("full_acc", 64'(obs_acc[3]), 64'(4));
        resp_pct = 100;
        cycle();
        check("full_same_cycle_refused", 64'(obs_acc[3]), 64'(4));
        cycle();
        check("full_release", 64'(obs_acc[3]), 64'(5));
        drain();

        // Response steering with backpressure from host 0
        clear_obs();
        resp_pct = 0;
        issue_one(1);
        issue_one(0);
        issue_one(2);
        dready_pct[0] = 0;
        resp_pct = 100;
        repeat (4) cycle();
        drain();
        check("steer_count", 64'(resp_order.size()), 64'(3));
        if (resp_order.size() >= 3) begin
            ord = resp_order[0] * 256 + resp_order[1] * 16 + resp_order[2];
            check("steer_order", 64'(ord), 64'(12'h102));
        end

        // Randomized traffic
        for (int seg = 0; seg < 15; seg++) begin
            host_en    = NH'($urandom_range(1, 15));
            req_pct    = $urandom_range(10, 100);
            ready_pct  = $urandom_range(0, 100);
            resp_pct   = $urandom_range(0, 100);
            orphan_pct = $urandom_range(0, 10);
            for (int h = 0; h < NH; h++) dready_pct[h] = $urandom_range(20, 100);
            repeat (200) cycle();
        end
        drain();

        // Orphan response with FIFO empty
        clear_obs();
        orphan_pct = 100;
        resp_pct = 0;
        cycle();
        orphan_pct = 0;
        repeat (3) cycle();
        check("orphan_err_pulses", 64'(obs_err), 64'(1));

        // Reset while Locked
        host_en = 4'b0001;
        ready_pct = 0;
        repeat (3) cycle();
        check("pre_reset_locked", 64'(sticky), 64'(0));
        rst = 1'b1;
        drive_noise();
        repeat (3) begin
            @(negedge clk);
            check_reset();
            @(posedge clk);
            #1 drive_noise();
        end
        rst = 1'b0;
        model_reset();
        quiet_knobs();
        repeat (2) cycle();
        check("post_reset_outstanding", 64'(outstanding_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

Round-robin arbiter that shares one TL-UL device port among `NumHosts` TL-UL host ports. It sits between several DV or RTL hosts and a single device. Requests are forwarded with zero added latency. The block records the winning host index of every accepted request in an in-order tracking FIFO and uses it to steer each device response back to its originating host. TL-UL responses return in order per device, so no source-ID rewriting is done.

## Interface
- `NumHosts`, default 4: number of host ports; legal range 2..8.
- `MaxOutstanding`, default 4: depth of the tracking FIFO; power of two, 2..16.
- `HostIdxW`, default `$clog2(NumHosts)`: derived; not overridable.
- `clk_i`, input, 1: single clock; everything is posedge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `tl_h_i`, input, `NumHosts` x `tlul_pkg::tl_h2d_t`: requests from the hosts.
- `tl_h_o`, output, `NumHosts` x `tlul_pkg::tl_d2h_t`: responses and `a_ready` to the hosts.
- `tl_d_o`, output, `tlul_pkg::tl_h2d_t`: request to the device.
- `tl_d_i`, input, `tlul_pkg::tl_d2h_t`: response and `a_ready` from the device.
- `outstanding_o`, output, `$clog2(MaxOutstanding)+1`: current FIFO occupancy.
- `err_o`, output, 1: one-cycle pulse when an orphan response is dropped.

## Operation
- **States.** `Idle` and `Locked`.
- **Idle.**
  - When the FIFO is not full, pick the first host with `a_valid`=1, searching round-robin from `rr_ptr`.
  - Drive the winner's `tl_h_i` onto `tl_d_o` combinationally, and return `tl_d_i.a_ready` to the winner only.
  - On handshake (`a_valid & a_ready`): push the winner index, set `rr_ptr` to winner+1 mod `NumHosts`, stay in `Idle`.
  - With no handshake and a non-zero grant: latch the grant and go to `Locked`.
- **Locked.** Forward only the latched host, as TL-UL forbids withdrawing `a_valid`. On handshake: push, update `rr_ptr`, go to `Idle`.
- **FIFO full.** `tl_d_o.a_valid`=0, all host `a_ready`=0, no state change. `Locked` is entered only when the FIFO is not full, so `Locked` never sees a full FIFO.
- **Response path.**
  - When the FIFO is non-empty, route `tl_d_i` (`d_valid` and payload) to host `head`. Every other host sees `d_valid`=0.
  - `tl_d_o.d_ready` equals `tl_h_i[head].d_ready`.
  - Pop on the d handshake.
- **Orphan response.** If `d_valid`=1 with the FIFO empty: `tl_d_o.d_ready`=1, the beat is dropped, and `err_o` pulses. The DV scoreboard flags this.
- **Same-cycle push and pop.** Both happen and occupancy is unchanged. The full check uses the registered occupancy, so a push is refused when full even if a pop happens in the same cycle.
- **Unused host outputs.** All fields of `tl_h_o` other than `a_ready`, `d_valid` and the d-payload are driven to 0.

## Timing
- **Request latency.** 0 cycles host→device, combinational.
- **Grant stability.** The grant is stable from the first cycle of `a_valid` until the handshake.
- **Response latency.** 0 cycles device→host, combinational.
- **Registered state.** Occupancy, `rr_ptr`, state and the latched grant update on the posedge after a handshake.
- **Reset values.**
  - `rr_ptr`=0, state `Idle`, FIFO empty.
  - `outstanding_o`=0, `err_o`=0.
  - `tl_d_o.a_valid`=0, `tl_d_o.d_ready`=0.
  - All host `a_ready`=0 and `d_valid`=0. This holds for the whole time `rst_i`=1 and does not depend on inputs.
- **Reset mid-transaction.** Outstanding entries are discarded without responses. Benches must reset the device model together with the block.
- **`err_o`.** Registered: it asserts the cycle after the orphan beat.

## Structure
- Add `tlul_host_arb_pkg` with:
  - the `arb_state_e` enum (`Idle`, `Locked`);
  - the `MaxHosts`=8 constant;
  - a `host_idx_t` typedef sized for `MaxHosts`.
- Reuse `tlul_pkg` for the TL-UL types.
- One sub-module: `tlul_host_arb_fifo`, a synchronous FIFO of `host_idx_t` with `full`, `empty` and `depth` outputs, same clock and reset.
- The round-robin search stays inline.

## Test plan
- **Single host.** Host 2 issues 3 back-to-back Gets; the device has ready=1 and 1-cycle responses → 3 responses on host 2 only, in order, and `outstanding_o` peaks at 1.
- **Round-robin fairness.** All 4 hosts hold `a_valid` continuously; the device is always ready → grant order 0,1,2,3,0,… and each host gets 25% of accepts over 64 cycles.
- **Grant lock.** Hosts 0 and 1 request; the device holds `a_ready`=0 for 5 cycles → host 0 stays granted all 5 cycles, and host 1 is granted on the cycle after host 0's handshake.
- **Full FIFO.** The device never responds; 5 requests from host 3 with `MaxOutstanding`=4 → 4 accepted, the 5th stalls with `a_ready`=0 and `outstanding_o`=4. One response releases the 5th on the following cycle.
- **Response steering and backpressure.** Requests from hosts 1, 0, 2 are accepted, then responses arrive; host 0 holds `d_ready`=0 for 3 cycles → responses reach 1, then 0, then 2, and `tl_d_o.d_ready` mirrors host 0's `d_ready` while host 0 is at the head.
- **Orphan and reset.** A response is injected with the FIFO empty → `d_ready`=1 and `err_o`=1 for exactly one cycle. Asserting `rst_i` mid-`Locked` → all outputs hold their reset values while `rst_i`=1, and `outstanding_o`=0 after release.
